// File: rtl/mlp_frame_sequencer_pkg.sv
// Shared types and default widths for the printed-MLP frame sequencer.
package mlp_frame_sequencer_pkg;

    localparam int FEAT_W     = 4;
    localparam int NUM_FEAT   = 4;
    localparam int OUT_W      = 19;
    localparam int FRAME_W    = NUM_FEAT * FEAT_W;
    localparam int CNT_W      = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
    localparam int SETTLE_MAX = 15;
    localparam int SETTLE_W   = $clog2(SETTLE_MAX + 1);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        OUTPUT = 2'd2
    } state_t;

endpackage

// File: rtl/mlp_frame_sequencer_settle.sv
// Loadable down-counter timing the settle window of the combinational core.
module settle_timer
    import mlp_frame_sequencer_pkg::*;
#(
    parameter int W = SETTLE_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/mlp_frame_sequencer.sv
// Loads feature nibbles into the core's input bus, waits out the settle window,
// then captures the core prediction and offers it on a valid/ready port.
module mlp_frame_sequencer
    import mlp_frame_sequencer_pkg::*;
#(
    parameter int NUM_FEAT   = mlp_frame_sequencer_pkg::NUM_FEAT,
    parameter int FEAT_W     = mlp_frame_sequencer_pkg::FEAT_W,
    parameter int OUT_W      = mlp_frame_sequencer_pkg::OUT_W,
    parameter int SETTLE_CYC = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [FEAT_W-1:0]            in_feat,
    output logic [NUM_FEAT*FEAT_W-1:0]   clf_inp,
    input  logic [OUT_W-1:0]             clf_out,
    output logic                         pred_valid,
    input  logic                         pred_ready,
    output logic [OUT_W-1:0]             pred_data
);

    localparam int FRAME_W = NUM_FEAT * FEAT_W;
    localparam int CNT_W   = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
    localparam logic [CNT_W-1:0]    LAST_SLOT   = CNT_W'(NUM_FEAT - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYC - 1);

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     feat_cnt;
    logic [FRAME_W-1:0]   clf_inp_r;
    logic [OUT_W-1:0]     pred_data_r;
    logic                 pred_valid_r;
    logic                 accept, final_accept, capture, handshake;
    logic                 timer_dec, timer_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // flush overrides every state and blocks a same-cycle accept
    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        final_accept = 1'b0;
        capture      = 1'b0;
        handshake    = 1'b0;
        timer_dec    = 1'b0;
        if (flush) begin
            state_nxt = LOAD;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        accept = 1'b1;
                        if (feat_cnt == LAST_SLOT) begin
                            final_accept = 1'b1;
                            state_nxt    = SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (timer_done) begin
                        capture   = 1'b1;
                        state_nxt = OUTPUT;
                    end else begin
                        timer_dec = 1'b1;
                    end
                end
                OUTPUT: begin
                    if (pred_valid_r && pred_ready) begin
                        handshake = 1'b1;
                        state_nxt = LOAD;
                    end
                end
                default: state_nxt = LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            feat_cnt     <= '0;
            clf_inp_r    <= '0;
            pred_data_r  <= '0;
            pred_valid_r <= 1'b0;
        end else if (flush) begin
            feat_cnt     <= '0;
            clf_inp_r    <= '0;
            pred_valid_r <= 1'b0;
        end else begin
            if (accept) begin
                clf_inp_r[feat_cnt*FEAT_W +: FEAT_W] <= in_feat;
                feat_cnt <= final_accept ? '0 : feat_cnt + 1'b1;
            end
            // clf_out is only trusted on the capture edge
            if (capture) begin
                pred_data_r  <= clf_out;
                pred_valid_r <= 1'b1;
            end else if (handshake) begin
                pred_valid_r <= 1'b0;
            end
        end
    end

    settle_timer #(
        .W(SETTLE_W)
    ) u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (flush),
        .load     (final_accept),
        .load_val (SETTLE_LOAD),
        .dec      (timer_dec),
        .done     (timer_done)
    );

    assign in_ready   = (state == LOAD);
    assign clf_inp    = clf_inp_r;
    assign pred_valid = pred_valid_r;
    assign pred_data  = pred_data_r;

endmodule

// File: tb/tb_mlp_frame_sequencer.sv
// Scoreboard bench: default instance for directed frames, SETTLE_CYC=1 instance for random handshakes.
module tb_mlp_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst, flush;

    logic        in_valid0, in_ready0, pred_valid0, pred_ready0;
    logic [3:0]  in_feat0;
    logic [15:0] clf_inp0;
    logic [18:0] clf_out0, pred_data0, core_val;

    logic        in_valid1, in_ready1, pred_valid1, pred_ready1;
    logic [3:0]  in_feat1;
    logic [15:0] clf_inp1;
    logic [18:0] clf_out1, pred_data1;

    logic [18:0] q0[$];
    logic [18:0] q1[$];
    int          checks = 0;
    int          errors = 0;
    int          recv1 = 0;
    bit          rand_run;

    always #5 clk = ~clk;

    function automatic logic [18:0] core_fn(input logic [15:0] x);
        return {3'b100, x ^ 16'hA5C3};
    endfunction

    assign clf_out0 = core_val;
    assign clf_out1 = core_fn(clf_inp1);

    mlp_frame_sequencer u_dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_feat(in_feat0),
        .clf_inp(clf_inp0), .clf_out(clf_out0),
        .pred_valid(pred_valid0), .pred_ready(pred_ready0), .pred_data(pred_data0)
    );

    mlp_frame_sequencer #(.SETTLE_CYC(1)) u_dut1 (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_feat(in_feat1),
        .clf_inp(clf_inp1), .clf_out(clf_out1),
        .pred_valid(pred_valid1), .pred_ready(pred_ready1), .pred_data(pred_data1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send0(input logic [3:0] f);
        in_valid0 = 1'b1;
        in_feat0  = f;
        step();
        in_valid0 = 1'b0;
    endtask

    // monitors: a handshake seen at the negedge completes on the next rising edge
    always @(negedge clk) begin
        if (!rst && pred_valid0 && pred_ready0) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL pred0_unexpected: got %0h expected none", pred_data0);
            end else begin
                chk("pred0_data", 32'(pred_data0), 32'(q0.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && pred_valid1 && pred_ready1) begin
            recv1++;
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL pred1_unexpected: got %0h expected none", pred_data1);
            end else begin
                chk("pred1_data", 32'(pred_data1), 32'(q1.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw;
        rst = 1'b1; flush = 1'b0;
        in_valid0 = 1'b0; in_feat0 = '0; pred_ready0 = 1'b0; core_val = '0;
        in_valid1 = 1'b0; in_feat1 = '0; pred_ready1 = 1'b0;
        step(); step();
        chk("rst_in_ready", 32'(in_ready0), 32'd1);
        chk("rst_pred_valid", 32'(pred_valid0), 32'd0);
        chk("rst_pred_data", 32'(pred_data0), 32'd0);
        chk("rst_clf_inp", 32'(clf_inp0), 32'd0);
        rst = 1'b0;
        step();

        // frame 1,2,3,4 with a constant core result
        pred_ready0 = 1'b1;
        core_val = 19'd12345;
        send0(4'd1); send0(4'd2); send0(4'd3); send0(4'd4);
        chk("t1_clf_inp", 32'(clf_inp0), 32'h4321);
        chk("t1_in_ready_settle", 32'(in_ready0), 32'd0);
        chk("t1_valid_E", 32'(pred_valid0), 32'd0);
        q0.push_back(19'd12345);
        step();
        chk("t1_valid_E1", 32'(pred_valid0), 32'd0);
        step();
        chk("t1_valid_E2", 32'(pred_valid0), 32'd0);
        step();
        chk("t1_valid_E3", 32'(pred_valid0), 32'd1);
        chk("t1_data_E3", 32'(pred_data0), 32'd12345);
        step();
        chk("t1_in_ready_after", 32'(in_ready0), 32'd1);

        // capture samples only the capture edge; then back-pressure
        pred_ready0 = 1'b0;
        core_val = 19'd7;
        send0(4'hA); send0(4'hB); send0(4'hC); send0(4'hD);
        step();
        core_val = 19'd999;
        step(); step();
        core_val = 19'd500;
        chk("t2_valid", 32'(pred_valid0), 32'd1);
        chk("t2_data", 32'(pred_data0), 32'd999);
        q0.push_back(19'd999);
        in_valid0 = 1'b1; in_feat0 = 4'h9;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t3_in_ready_hold", 32'(in_ready0), 32'd0);
            chk("t3_data_hold", 32'(pred_data0), 32'd999);
        end
        chk("t3_no_accept", 32'(clf_inp0), 32'hDCBA);
        in_valid0 = 1'b0;
        pred_ready0 = 1'b1;
        step();
        chk("t3_in_ready_next", 32'(in_ready0), 32'd1);
        chk("t3_valid_drop", 32'(pred_valid0), 32'd0);

        // flush mid-load, then a fresh frame with bit 18 set in the result
        send0(4'd1); send0(4'd2);
        chk("t4_partial", 32'(clf_inp0), 32'hDC21);
        in_valid0 = 1'b1; in_feat0 = 4'd3; flush = 1'b1;
        step();
        flush = 1'b0; in_valid0 = 1'b0;
        chk("t4_flush_clf_inp", 32'(clf_inp0), 32'd0);
        chk("t4_flush_in_ready", 32'(in_ready0), 32'd1);
        core_val = 19'h48765;
        send0(4'd5); send0(4'd6); send0(4'd7); send0(4'd8);
        chk("t4_clf_inp", 32'(clf_inp0), 32'h8765);
        q0.push_back(19'h48765);
        repeat (5) step();
        chk("t4_drain", 32'(q0.size()), 32'd0);

        // async reset during SETTLE
        core_val = 19'd555;
        send0(4'd1); send0(4'd1); send0(4'd1); send0(4'd1);
        step();
        rst = 1'b1;
        #1;
        chk("t5_pred_valid", 32'(pred_valid0), 32'd0);
        chk("t5_in_ready", 32'(in_ready0), 32'd1);
        chk("t5_clf_inp", 32'(clf_inp0), 32'd0);
        chk("t5_pred_data", 32'(pred_data0), 32'd0);
        #2;
        rst = 1'b0;
        saw = 1'b0;
        repeat (8) begin
            step();
            if (pred_valid0) saw = 1'b1;
        end
        chk("t5_no_pulse", 32'(saw), 32'd0);

        // SETTLE_CYC=1 instance, random valid and ready, 200 frames
        rand_run = 1'b1;
        fork
            begin
                for (int f = 0; f < 200; f++) begin
                    logic [15:0] fr;
                    fr = '0;
                    for (int k = 0; k < 4; k++) begin
                        bit acc;
                        int tries;
                        logic [3:0] v;
                        v = 4'($urandom_range(0, 15));
                        fr[k*4 +: 4] = v;
                        in_feat1 = v;
                        acc = 1'b0;
                        tries = 0;
                        while (!acc && tries < 1000) begin
                            in_valid1 = 1'($urandom % 2);
                            acc = in_valid1 && in_ready1;
                            step();
                            tries++;
                        end
                        if (!acc) begin
                            checks++; errors++;
                            $display("FAIL t6_accept_timeout: got none expected accept frame %0d", f);
                        end
                    end
                    q1.push_back(core_fn(fr));
                end
                in_valid1 = 1'b0;
                rand_run = 1'b0;
            end
            begin
                while (rand_run) begin
                    pred_ready1 = 1'($urandom % 2);
                    step();
                end
            end
        join
        pred_ready1 = 1'b1;
        for (int i = 0; i < 50 && q1.size() != 0; i++) step();
        step();
        chk("t6_queue_empty", 32'(q1.size()), 32'd0);
        chk("t6_frames", 32'(recv1), 32'd200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
